// File: rtl/ter_intlv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ter_intlv_ctrl_pkg
// Shared definitions for the TER interleaver frame sequencer:
//   - sequencer state enum (IDLE, LOAD, WRITE, GAP, READ)
//   - err_code values
//   - legal link-ID range
//   - link-ID -> interleaver length table (link_len)
// ---------------------------------------------------------------------------
package ter_intlv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_GAP   = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_LINK     = 2'b01;
  localparam logic [1:0] ERR_UNDERRUN = 2'b10;

  localparam logic [4:0] LINK_MIN = 5'd11;
  localparam logic [4:0] LINK_MAX = 5'd19;

  // Native width of the length table; every entry fits in 13 bits.
  localparam int TBL_W = 13;

  // Link-ID to interleaver length. Out-of-range IDs map to zero.
  function automatic logic [TBL_W-1:0] link_len(input logic [4:0] link);
    logic [TBL_W-1:0] len;
    case (link)
      5'd11:   len = 13'd432;
      5'd12:   len = 13'd972;
      5'd13:   len = 13'd1296;
      5'd14:   len = 13'd896;
      5'd15:   len = 13'd2016;
      5'd16:   len = 13'd2688;
      5'd17:   len = 13'd1872;
      5'd18:   len = 13'd4032;
      5'd19:   len = 13'd5616;
      default: len = 13'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ter_len_lut.sv
// ---------------------------------------------------------------------------
// ter_len_lut
// Combinational link-ID -> interleaver length map with a legality flag.
// Ports:
//   link_i   [4:0]       link ID from the frame descriptor
//   len_o    [LEN_W-1:0] interleaver length (0 when illegal)
//   legal_o              1 when link_i is within LINK_MIN..LINK_MAX
// ---------------------------------------------------------------------------
module ter_len_lut
  import ter_intlv_ctrl_pkg::*;
#(
  parameter int LEN_W = 13
) (
  input  logic [4:0]       link_i,
  output logic [LEN_W-1:0] len_o,
  output logic             legal_o
);

  // Range check and table lookup.
  always_comb begin
    len_o   = {LEN_W{1'b0}};
    legal_o = 1'b0;
    if ((link_i >= LINK_MIN) && (link_i <= LINK_MAX)) begin
      legal_o = 1'b1;
      len_o   = LEN_W'(link_len(link_i));
    end else begin
      legal_o = 1'b0;
      len_o   = {LEN_W{1'b0}};
    end
  end

endmodule

// File: rtl/ter_intlv_ctrl.sv
// ---------------------------------------------------------------------------
// ter_intlv_ctrl
// Frame sequencer for the TER interleaver enable/address generator.
// Accepts a link-ID descriptor, maps it to m_len, then runs a contiguous
// write phase (din_vld) followed, after GAP idle cycles, by a flow-controlled
// read phase (request = m_rdy).
// Ports:
//   clk, n_rst         clock, async active-low reset
//   cfg_vld/cfg_link   frame descriptor; cfg_rdy high in IDLE
//   s_vld/s_rdy        upstream sample handshake (s_rdy = write strobe)
//   m_rdy              downstream ready, gates request in READ
//   m_len              interleaver length, 0 in IDLE
//   din_vld, request   write / read strobes
//   busy               not in IDLE
//   frame_done         pulse with the last request of a frame
//   err, err_code      error pulse and sticky cause (01 bad link, 10 underrun)
// Optional (macro TER_CTRL_FRM_CNT_EN):
//   frm_cnt [15:0]     completed frames, wrapping
//   err_cnt [15:0]     err pulses, saturating
// ---------------------------------------------------------------------------
module ter_intlv_ctrl
  import ter_intlv_ctrl_pkg::*;
#(
  parameter int LEN_W = 13,
  parameter int CNT_W = 16,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cfg_vld,
  input  logic [4:0]       cfg_link,
  output logic             cfg_rdy,
  input  logic             s_vld,
  output logic             s_rdy,
  input  logic             m_rdy,
  output logic [LEN_W-1:0] m_len,
  output logic             din_vld,
  output logic             request,
  output logic             busy,
  output logic             frame_done,
  output logic             err,
  output logic [1:0]       err_code
`ifdef TER_CTRL_FRM_CNT_EN
  ,
  output logic [15:0]      frm_cnt,
  output logic [15:0]      err_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] m_len_q, m_len_d;
  logic             uflow_q, uflow_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [LEN_W-1:0] lut_len_s;
  logic             lut_legal_s;
  logic             cnt_last_s;

  ter_len_lut #(
    .LEN_W (LEN_W)
  ) u_len_lut (
    .link_i  (cfg_link),
    .len_o   (lut_len_s),
    .legal_o (lut_legal_s)
  );

  assign cnt_last_s = ((cnt_q + CNT_W'(1)) == CNT_W'(m_len_q));

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_len_d    = m_len_q;
    uflow_d    = uflow_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    cfg_rdy    = 1'b0;
    s_rdy      = 1'b0;
    din_vld    = 1'b0;
    request    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_rdy = 1'b1;
        if (cfg_vld) begin
          if (lut_legal_s) begin
            m_len_d = lut_len_s;
            state_d = ST_LOAD;
          end else begin
            // Illegal descriptor is dropped; only the error is reported.
            err_d      = 1'b1;
            err_code_d = ERR_LINK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Being here for at least one cycle lets the generator register its offset.
        if (s_vld) begin
          state_d = ST_WRITE;
          cnt_d   = {CNT_W{1'b0}};
          uflow_d = 1'b0;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        din_vld = 1'b1;
        s_rdy   = 1'b1;
        // Missing samples never stall the write; report once per frame.
        if (!s_vld && !uflow_q) begin
          err_d      = 1'b1;
          err_code_d = ERR_UNDERRUN;
          uflow_d    = 1'b1;
        end else begin
          uflow_d = uflow_q;
        end
        if (cnt_last_s) begin
          state_d = ST_GAP;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        // The sample counter doubles as the gap timer.
        if (cnt_q == CNT_W'(GAP - 1)) begin
          state_d = ST_READ;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READ: begin
        request = m_rdy;
        if (m_rdy) begin
          if (cnt_last_s) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
            m_len_d    = {LEN_W{1'b0}};
            cnt_d      = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        m_len_d = {LEN_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, counter, length and error registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      m_len_q    <= {LEN_W{1'b0}};
      uflow_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_len_q    <= m_len_d;
      uflow_q    <= uflow_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign m_len    = m_len_q;
  assign err      = err_q;
  assign err_code = err_code_q;

`ifdef TER_CTRL_FRM_CNT_EN
  logic [15:0] frm_cnt_q, frm_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Frame counter wraps; error counter saturates.
  always_comb begin
    frm_cnt_d = frm_cnt_q;
    err_cnt_d = err_cnt_q;
    if (frame_done) begin
      frm_cnt_d = frm_cnt_q + 16'd1;
    end else begin
      frm_cnt_d = frm_cnt_q;
    end
    if (err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frm_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      frm_cnt_q <= frm_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign frm_cnt = frm_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ter_intlv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ter_intlv_ctrl
// Directed bench for ter_intlv_ctrl. A frame-level model predicts every
// output each cycle from the accept cycle and the length table; directed
// tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ter_intlv_ctrl;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cfg_vld;
  logic [4:0]  cfg_link;
  logic        cfg_rdy;
  logic        s_vld;
  logic        s_rdy;
  logic        m_rdy = 1'b0;
  logic [12:0] m_len;
  logic        din_vld;
  logic        request;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic [1:0]  err_code;
`ifdef TER_CTRL_FRM_CNT_EN
  logic [15:0] frm_cnt;
  logic [15:0] err_cnt;
`endif

  ter_intlv_ctrl #(.LEN_W(13), .CNT_W(16), .GAP(GAP)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cfg_vld    (cfg_vld),
    .cfg_link   (cfg_link),
    .cfg_rdy    (cfg_rdy),
    .s_vld      (s_vld),
    .s_rdy      (s_rdy),
    .m_rdy      (m_rdy),
    .m_len      (m_len),
    .din_vld    (din_vld),
    .request    (request),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .err_code   (err_code)
`ifdef TER_CTRL_FRM_CNT_EN
    ,
    .frm_cnt    (frm_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  bit rnd_en = 1'b0;
  logic rdy_val = 1'b0;
  int len_tab [32];

  // Model state
  bit         m_act = 1'b0;
  int         m_t, m_l, m_nreq;
  bit         m_uf = 1'b0;
  bit         m_pend = 1'b0;
  logic [1:0] m_pend_code = 2'b00;
  logic [1:0] m_code = 2'b00;

  // Activity monitors
  int n_din = 0, n_req = 0, n_fd = 0, n_err = 0, n_busy = 0;
  int acc_cyc = 0, fd_cyc = 0, last_din = 0, first_req = 0;
  bit req_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: constant or random 50%
  always @(posedge clk) begin
    #1;
    m_rdy = rnd_en ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Per-cycle compare against the frame-level model
  always @(negedge clk) begin
    logic e_rdy, e_busy, e_din, e_req, e_fd, e_err;
    int   e_len;
    if (!n_rst) begin
      m_act = 1'b0; m_pend = 1'b0; m_code = 2'b00; m_nreq = 0;
      chk("rst_busy", busy, 0);
      chk("rst_cfg_rdy", cfg_rdy, 1);
      chk("rst_strobes", {din_vld, request, frame_done, err}, 0);
      chk("rst_m_len", m_len, 0);
      chk("rst_err_code", err_code, 0);
    end else begin
      e_err = m_pend;
      if (m_pend) m_code = m_pend_code;
      m_pend = 1'b0;
      if (m_act) begin
        e_rdy  = 1'b0;
        e_busy = 1'b1;
        e_len  = m_l;
        e_din  = (cyc >= m_t + 2) && (cyc <= m_t + 1 + m_l);
        e_req  = (cyc >= m_t + 2 + m_l + GAP) ? m_rdy : 1'b0;
        e_fd   = e_req && (m_nreq == m_l - 1);
      end else begin
        e_rdy = 1'b1; e_busy = 1'b0; e_len = 0;
        e_din = 1'b0; e_req = 1'b0; e_fd = 1'b0;
      end
      chk("cfg_rdy", cfg_rdy, e_rdy);
      chk("busy", busy, e_busy);
      chk("m_len", m_len, e_len);
      chk("din_vld", din_vld, e_din);
      chk("s_rdy", s_rdy, e_din);
      chk("request", request, e_req);
      chk("frame_done", frame_done, e_fd);
      chk("err", err, e_err);
      chk("err_code", err_code, m_code);

      if (din_vld) begin n_din++; last_din = cyc; req_seen = 1'b0; end
      if (request) begin
        n_req++;
        if (!req_seen) begin first_req = cyc; req_seen = 1'b1; end
      end
      if (frame_done) begin n_fd++; fd_cyc = cyc; end
      if (err) n_err++;
      if (busy) n_busy++;

      if (m_act) begin
        if (e_din && !s_vld && !m_uf) begin
          m_pend = 1'b1; m_pend_code = 2'b10; m_uf = 1'b1;
        end
        if (e_req) m_nreq++;
        if (e_fd) m_act = 1'b0;
      end else if (cfg_vld) begin
        if (len_tab[cfg_link] != 0) begin
          m_act = 1'b1; m_t = cyc; m_l = len_tab[cfg_link];
          m_nreq = 0; m_uf = 1'b0; acc_cyc = cyc;
        end else begin
          m_pend = 1'b1; m_pend_code = 2'b01;
        end
      end
    end
  end

  task automatic start_frame(input logic [4:0] link);
    @(posedge clk); #1;
    cfg_vld = 1'b1; cfg_link = link;
    @(posedge clk); #1;
    cfg_vld = 1'b0;
  endtask

  // Returns #1 after the edge following frame_done.
  task automatic wait_done(input int budget);
    int f0;
    int k;
    f0 = n_fd;
    k  = 0;
    while (n_fd == f0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("done_timeout", (n_fd != f0), 1);
    #1;
  endtask

  initial begin
    int d0, r0, e0, b0, f0, k;
    for (int i = 0; i < 32; i++) len_tab[i] = 0;
    len_tab[11] = 432;  len_tab[12] = 972;  len_tab[13] = 1296;
    len_tab[14] = 896;  len_tab[15] = 2016; len_tab[16] = 2688;
    len_tab[17] = 1872; len_tab[18] = 4032; len_tab[19] = 5616;

    n_rst = 1'b0; cfg_vld = 1'b0; cfg_link = 5'd0; s_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cfg_rdy", cfg_rdy, 1);
    chk("reset_busy", busy, 0);
    chk("reset_m_len", m_len, 0);
    chk("reset_strobes", {din_vld, request, frame_done, err}, 0);

    // Link 11 nominal
    s_vld = 1'b1; rdy_val = 1'b1;
    d0 = n_din; r0 = n_req;
    start_frame(5'd11);
    wait_done(2000);
    chk("l11_din_count", n_din - d0, 432);
    chk("l11_req_count", n_req - r0, 432);
    chk("l11_gap", first_req - last_din - 1, 2);
    // Accept cycle through frame_done cycle inclusive
    chk("l11_latency", fd_cyc - acc_cyc + 1, 868);

    // Link 19 with random backpressure
    rnd_en = 1'b1;
    r0 = n_req;
    start_frame(5'd19);
    chk("l19_m_len", m_len, 13'h15F0);
    wait_done(30000);
    chk("l19_req_count", n_req - r0, 5616);
    rnd_en = 1'b0;

    // Illegal links 7 and 20
    e0 = n_err; b0 = n_busy; d0 = n_din; r0 = n_req;
    @(posedge clk); #1 cfg_vld = 1'b1; cfg_link = 5'd7;
    @(posedge clk); #1 cfg_vld = 1'b0;
    @(posedge clk); #1 cfg_vld = 1'b1; cfg_link = 5'd20;
    @(posedge clk); #1 cfg_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ill_err_pulses", n_err - e0, 2);
    chk("ill_err_code", err_code, 2'b01);
    chk("ill_busy", n_busy - b0, 0);
    chk("ill_strobes", (n_din - d0) + (n_req - r0), 0);

    // Underrun on link 14
    d0 = n_din; e0 = n_err;
    start_frame(5'd14);
    repeat (50) @(posedge clk);
    #1 s_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 s_vld = 1'b1;
    wait_done(4000);
    chk("ur_din_count", n_din - d0, 896);
    chk("ur_err_pulses", n_err - e0, 1);
    chk("ur_err_code", err_code, 2'b10);

    // Abort link 16 in READ by reset
    r0 = n_req;
    start_frame(5'd16);
    k = 0;
    while (n_req == r0 && k < 8000) begin
      @(posedge clk);
      k++;
    end
    chk("ab_reach_read", (n_req != r0), 1);
    @(posedge clk); #1;
    chk("ab_req_before", request, 1);
    f0 = n_fd;
    #2 n_rst = 1'b0;
    #1;
    chk("ab_req_drop", request, 0);
    chk("ab_busy_drop", busy, 0);
    chk("ab_din_drop", din_vld, 0);
    chk("ab_m_len_drop", m_len, 0);
    @(negedge clk);
    @(posedge clk); #1 n_rst = 1'b1;
    chk("ab_no_done", n_fd - f0, 0);

    // Clean link 12 frame; an illegal descriptor is held throughout and must
    // only be taken once the block is back in IDLE
    d0 = n_din; r0 = n_req; e0 = n_err;
    start_frame(5'd12);
    cfg_vld = 1'b1; cfg_link = 5'd20;
    wait_done(3000);
    @(posedge clk); #1 cfg_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("l12_din_count", n_din - d0, 972);
    chk("l12_req_count", n_req - r0, 972);
    chk("l12_err_pulses", n_err - e0, 1);
    chk("l12_err_code", err_code, 2'b01);
`ifdef TER_CTRL_FRM_CNT_EN
    chk("frm_cnt", frm_cnt, 16'd1);
    chk("err_cnt", err_cnt, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ter_intlv_ctrl.md
# ter_intlv_ctrl

Frame sequencer for the TER interleaver enable/address generator. It accepts a per-frame link-ID descriptor and maps it to the interleaver length `m_len`. It then drives the generator through a contiguous write phase (`din_vld`) and a flow-controlled read phase (`request`). It sits between the upstream symbol source, the interleaver enable/RAM pair and the downstream consumer, and owns all frame-boundary and error decisions.

## Interface
- `LEN_W`, 13: width of `m_len`.
- `CNT_W`, 16: width of internal sample counters (matches interleaver address width).
- `GAP`, 2: idle cycles between the end of the write phase and the first `request`. Legal range is ≥2.
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `cfg_vld` in 1: frame descriptor valid.
- `cfg_link` in 5: link ID. Legal values are 11..19 decimal.
- `cfg_rdy` out 1: descriptor accepted on `cfg_vld & cfg_rdy`.
- `s_vld` in 1: upstream sample valid.
- `s_rdy` out 1: upstream sample taken.
- `m_rdy` in 1: downstream can take one interleaved sample.
- `m_len` out `LEN_W`: length to the interleaver.
- `din_vld` out 1: write-phase strobe.
- `request` out 1: read strobe, one per sample.
- `busy` out 1: high whenever the block is not in IDLE.
- `frame_done` out 1: one-cycle pulse when the last request is issued.
- `err` out 1: one-cycle pulse on an error event.
- `err_code` out 2: cause of the latest error. 01 = bad link, 10 = underrun. Holds until the next error.

## Operation
- Length map (link→m_len): 11→432, 12→972, 13→1296, 14→896, 15→2016, 16→2688, 17→1872, 18→4032, 19→5616.
- FSM states:
  - IDLE: `cfg_rdy`=1.
    - Accept with a legal link → LOAD, with `m_len` registered.
    - Accept with an illegal link → stay in IDLE; pulse `err`, set `err_code`=01. The descriptor is dropped.
  - LOAD: `m_len` is stable and the block waits for `s_vld`=1. It spends a minimum of one cycle here so the generator can register its offset. When `s_vld`=1 after that minimum → WRITE.
  - WRITE: `din_vld`=`s_rdy`=1 for exactly `m_len` consecutive cycles, regardless of `s_vld`.
    - `s_vld`=0 on any WRITE cycle → one `err` pulse per frame, `err_code`=10. The frame continues.
    - Count reaches `m_len`-1 → GAP.
  - GAP: `GAP` cycles with all strobes low, then → READ.
  - READ: `request` = `m_rdy`. Each cycle with `request`=1 increments the count.
    - On the `m_len`-th request, pulse `frame_done` in that same cycle → IDLE.
- Counting:
  - Counters are `CNT_W` wide and cleared on every entry to WRITE and READ.
  - Terminal compare is `cnt + 1 == m_len`, zero-extended.
- `m_len` is held from LOAD through the last READ cycle and driven to 0 in IDLE.
- Descriptors are not accepted while `busy`; there is no queueing.

## Timing
- Reset values:
  - `cfg_rdy`=1 (IDLE).
  - All other outputs 0, `err_code`=00, state IDLE.
- Accept at cycle T:
  - `m_len` is valid from T+1.
  - The earliest `din_vld` is at T+2.
- The last `din_vld` is at W. The first possible `request` is at W+GAP+1.
- `request` has zero-cycle combinational dependence on `m_rdy` in READ only.
- Total frame latency with `s_vld` and `m_rdy` held high is 2 + `m_len` + `GAP` + `m_len` cycles from accept to `frame_done`.
- Reset asserted mid-frame forces IDLE immediately (asynchronous) and drops all strobes. No `frame_done` is issued.
- `cfg_vld` in the `frame_done` cycle is not accepted. It is accepted on the next cycle (IDLE).

## Configuration
- `TER_CTRL_FRM_CNT_EN` defined:
  - Adds output `frm_cnt` (16-bit), reset 0, incremented on each `frame_done`. It wraps at 0xFFFF→0.
  - Also adds output `err_cnt` (16-bit), which counts `err` pulses and saturates at 0xFFFF.
- `TER_CTRL_FRM_CNT_EN` not defined: neither port nor counter exists. All other behaviour is identical.

## Structure
- The shared package holds:
  - the state enum (IDLE, LOAD, WRITE, GAP, READ);
  - the `err_code` constants;
  - the link-ID range constants;
  - the link→m_len table.
- One sub-module, `ter_len_lut`: a combinational link→m_len map with a `legal` flag. The FSM and counters stay in the top level.

## Test plan
- Reset values:
  - Stimulus: reset, release, no stimulus.
  - Required: `cfg_rdy`=1, `busy`=0, all strobes 0, `m_len`=0.
- Link 11, nominal:
  - Stimulus: link 11, `s_vld`=`m_rdy`=1.
  - Required: 432 `din_vld` cycles, 2 gap cycles, 432 `request` cycles, and `frame_done` exactly 868 cycles after accept.
- Link 19, random backpressure:
  - Stimulus: link 19, `m_rdy` random 50%.
  - Required: exactly 5616 `request` pulses, `frame_done` on the last one, and `m_len`=0x15F0 stable throughout.
- Illegal link:
  - Stimulus: `cfg_link`=7, then 20.
  - Required: two `err` pulses, `err_code`=01, `busy` stays 0, no strobes.
- Underrun:
  - Stimulus: link 14, `s_vld` low for 3 cycles mid-WRITE.
  - Required: a single `err` pulse, `err_code`=10, and still exactly 896 `din_vld` cycles.
- Abort by reset:
  - Stimulus: `n_rst` pulsed low in READ of link 16, then a new link-12 frame.
  - Required: strobes drop asynchronously, then a clean 972/972 frame. With `TER_CTRL_FRM_CNT_EN`, `frm_cnt`=1.
